// File: rtl/canny_frame_controller.sv
// -----------------------------------------------------------------------------
// canny_frame_controller
//
// Frame-level sequencer around the Canny edge pipeline. It accepts one frame
// from the host under valid/ready and forwards it to the pipeline, which has
// no backpressure. It then injects zero pixels so the pipeline's line buffers
// drain. Edge results are forwarded with a last flag, and the controller
// reports frame completion, a drain timeout and output overflow.
//
// Ports:
//   clk, rstN           clock, synchronous active-low reset
//   start, abort        single-cycle frame start / abort requests
//   host_pixel/valid    host pixel stream in; host_ready accepts it (RUN only)
//   pipe_pixel/valid    registered pixel stream into the pipeline
//   edge_in/valid       pipeline result stream
//   out_pixel/valid     registered forwarded results; out_last on final pixel
//   busy                controller is not idle
//   frame_done          one-cycle completion pulse
//   timeout_err         sticky: drain saw no output for DRAIN_TIMEOUT cycles
//   overflow_err        sticky: pipeline produced more than OUT_PIXELS results
//   row, col            position of the next host pixel within the frame
// -----------------------------------------------------------------------------
module canny_frame_controller #(
    parameter int IMG_WIDTH     = 64,
    parameter int IMG_HEIGHT    = 64,
    parameter int FLUSH_PIXELS  = 640,
    parameter int OUT_PIXELS    = 3136,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          start,
    input  logic                          abort,
    input  logic [7:0]                    host_pixel,
    input  logic                          host_valid,
    output logic                          host_ready,
    output logic [7:0]                    pipe_pixel,
    output logic                          pipe_pixel_valid,
    input  logic [7:0]                    edge_in,
    input  logic                          edge_in_valid,
    output logic [7:0]                    out_pixel,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          timeout_err,
    output logic                          overflow_err,
    output logic [$clog2(IMG_HEIGHT)-1:0] row,
    output logic [$clog2(IMG_WIDTH)-1:0]  col
);

    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int IN_W    = $clog2(IMG_WIDTH * IMG_HEIGHT) + 1;
    localparam int OUT_W   = $clog2(OUT_PIXELS) + 1;
    localparam int FLUSH_W = $clog2(FLUSH_PIXELS) + 1;
    localparam int TMO_W   = $clog2(DRAIN_TIMEOUT) + 1;

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [OUT_W-1:0]   OUT_MAX    = OUT_W'(OUT_PIXELS);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_PIXELS - 1);
    localparam logic [TMO_W-1:0]   TMO_MAX    = TMO_W'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [ROW_W-1:0]     row_reg, row_next;
    logic [COL_W-1:0]     col_reg, col_next;
    logic [IN_W-1:0]      in_count_reg, in_count_next;
    logic [OUT_W-1:0]     out_count_reg, out_count_next;
    logic [FLUSH_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic [TMO_W-1:0]     timeout_cnt_reg, timeout_cnt_next;
    logic [7:0]           pipe_pixel_reg, pipe_pixel_next;
    logic                 pipe_pixel_valid_reg, pipe_pixel_valid_next;
    logic [7:0]           out_pixel_reg, out_pixel_next;
    logic                 out_valid_reg, out_valid_next;
    logic                 out_last_reg, out_last_next;
    logic                 timeout_err_reg, timeout_err_next;
    logic                 overflow_err_reg, overflow_err_next;
    logic                 transfer;

    assign host_ready       = (state_reg == RUN);
    assign busy             = (state_reg != IDLE);
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign frame_done       = (state_reg == DONE) && !abort;
    assign transfer         = host_ready && host_valid;

    assign pipe_pixel       = pipe_pixel_reg;
    assign pipe_pixel_valid = pipe_pixel_valid_reg;
    assign out_pixel        = out_pixel_reg;
    assign out_valid        = out_valid_reg;
    assign out_last         = out_last_reg;
    assign timeout_err      = timeout_err_reg;
    assign overflow_err     = overflow_err_reg;
    assign row              = row_reg;
    assign col              = col_reg;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_reg            <= IDLE;
            row_reg              <= '0;
            col_reg              <= '0;
            in_count_reg         <= '0;
            out_count_reg        <= '0;
            flush_cnt_reg        <= '0;
            timeout_cnt_reg      <= '0;
            pipe_pixel_reg       <= '0;
            pipe_pixel_valid_reg <= 1'b0;
            out_pixel_reg        <= '0;
            out_valid_reg        <= 1'b0;
            out_last_reg         <= 1'b0;
            timeout_err_reg      <= 1'b0;
            overflow_err_reg     <= 1'b0;
        end else begin
            state_reg            <= state_next;
            row_reg              <= row_next;
            col_reg              <= col_next;
            in_count_reg         <= in_count_next;
            out_count_reg        <= out_count_next;
            flush_cnt_reg        <= flush_cnt_next;
            timeout_cnt_reg      <= timeout_cnt_next;
            pipe_pixel_reg       <= pipe_pixel_next;
            pipe_pixel_valid_reg <= pipe_pixel_valid_next;
            out_pixel_reg        <= out_pixel_next;
            out_valid_reg        <= out_valid_next;
            out_last_reg         <= out_last_next;
            timeout_err_reg      <= timeout_err_next;
            overflow_err_reg     <= overflow_err_next;
        end
    end

    always_comb begin
        state_next            = state_reg;
        row_next              = row_reg;
        col_next              = col_reg;
        in_count_next         = in_count_reg;
        out_count_next        = out_count_reg;
        flush_cnt_next        = flush_cnt_reg;
        timeout_cnt_next      = timeout_cnt_reg;
        pipe_pixel_next       = pipe_pixel_reg;
        pipe_pixel_valid_next = 1'b0;
        out_pixel_next        = out_pixel_reg;
        out_valid_next        = 1'b0;
        out_last_next         = 1'b0;
        timeout_err_next      = timeout_err_reg;
        overflow_err_next     = overflow_err_reg;

        // Result path runs in every active state, so outputs that arrive while
        // the frame is still streaming in are counted as well.
        if (state_reg != IDLE && edge_in_valid) begin
            if (out_count_reg < OUT_MAX) begin
                out_pixel_next = edge_in;
                out_valid_next = 1'b1;
                out_count_next = out_count_reg + OUT_W'(1);
                out_last_next  = ((out_count_reg + OUT_W'(1)) == OUT_MAX);
            end else begin
                overflow_err_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next        = RUN;
                    row_next          = '0;
                    col_next          = '0;
                    in_count_next     = '0;
                    flush_cnt_next    = '0;
                    out_count_next    = '0;
                    timeout_cnt_next  = '0;
                    timeout_err_next  = 1'b0;
                    overflow_err_next = 1'b0;
                end
            end
            RUN: begin
                if (transfer) begin
                    pipe_pixel_next       = host_pixel;
                    pipe_pixel_valid_next = 1'b1;
                    in_count_next         = in_count_reg + IN_W'(1);
                    if (col_reg == COL_LAST) begin
                        col_next = '0;
                        if (row_reg == ROW_LAST) begin
                            row_next   = '0;
                            state_next = (FLUSH_PIXELS == 0) ? DRAIN : FLUSH;
                        end else begin
                            row_next = row_reg + ROW_W'(1);
                        end
                    end else begin
                        col_next = col_reg + COL_W'(1);
                    end
                end
            end
            FLUSH: begin
                pipe_pixel_next       = '0;
                pipe_pixel_valid_next = 1'b1;
                flush_cnt_next        = flush_cnt_reg + FLUSH_W'(1);
                if (flush_cnt_reg == FLUSH_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                timeout_cnt_next = edge_in_valid ? '0 : timeout_cnt_reg + TMO_W'(1);
                // A complete output count wins over a timeout on the same cycle.
                if (out_count_reg == OUT_MAX) begin
                    state_next = DONE;
                end else if (timeout_cnt_next == TMO_MAX) begin
                    timeout_err_next = 1'b1;
                    state_next       = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort freezes every counter and sticky flag where it stands and
        // returns to IDLE; the next start re-initialises everything.
        if (abort && state_reg != IDLE) begin
            state_next            = IDLE;
            row_next              = row_reg;
            col_next              = col_reg;
            in_count_next         = in_count_reg;
            out_count_next        = out_count_reg;
            flush_cnt_next        = flush_cnt_reg;
            timeout_cnt_next      = timeout_cnt_reg;
            pipe_pixel_next       = pipe_pixel_reg;
            pipe_pixel_valid_next = 1'b0;
            out_pixel_next        = out_pixel_reg;
            out_valid_next        = 1'b0;
            out_last_next         = 1'b0;
            timeout_err_next      = timeout_err_reg;
            overflow_err_next     = overflow_err_reg;
        end
    end

endmodule

// File: tb/tb_canny_frame_controller.sv
// -----------------------------------------------------------------------------
// Testbench for canny_frame_controller with a small 4x2 frame.
// A scenario table drives whole frames with random pixel data, random host
// gaps and edge pulses placed either during RUN or during DRAIN. Expected
// pipeline and output streams are kept as time-stamped queues; expected
// completion latency and error flags come from the table.
// -----------------------------------------------------------------------------
module tb_canny_frame_controller;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FP = 3;
    localparam int OP = 2;
    localparam int DT = 5;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start, abort;
    logic [7:0] host_pixel;
    logic       host_valid, host_ready;
    logic [7:0] pipe_pixel;
    logic       pipe_pixel_valid;
    logic [7:0] edge_in;
    logic       edge_in_valid;
    logic [7:0] out_pixel;
    logic       out_valid, out_last, busy, frame_done, timeout_err, overflow_err;
    logic [$clog2(H)-1:0] row;
    logic [$clog2(W)-1:0] col;

    always #5 clk = ~clk;

    canny_frame_controller #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_PIXELS(FP),
        .OUT_PIXELS(OP), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rstN(rstN), .start(start), .abort(abort),
        .host_pixel(host_pixel), .host_valid(host_valid), .host_ready(host_ready),
        .pipe_pixel(pipe_pixel), .pipe_pixel_valid(pipe_pixel_valid),
        .edge_in(edge_in), .edge_in_valid(edge_in_valid),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
        .overflow_err(overflow_err), .row(row), .col(col)
    );

    typedef struct {
        int gap;        // 0: host_valid always high, else 1-in-(gap+1) chance
        int n_edges;    // edge_in_valid pulses in the frame
        bit in_drain;   // pulses during DRAIN (1) or at the start of RUN (0)
        bit exp_to;
        bit exp_ov;
        int exp_lat;    // cycles from final host transfer to frame_done
    } scen_t;

    typedef struct {
        int         cyc;
        logic [7:0] v;
        logic       last;
    } ev_t;

    ev_t   pipe_q[$];
    ev_t   out_q[$];
    scen_t tbl[6];
    int    checks = 0, errors = 0;
    int    cyc = 0, done_seen = 0, done_cyc = 0, edges_fwd = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, release single-cycle inputs, and check the streams.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0; abort = 1'b0; edge_in_valid = 1'b0; host_valid = 1'b0;
        if (pipe_q.size() > 0 && pipe_q[0].cyc == cyc) begin
            chk("pipe_valid", int'(pipe_pixel_valid), 1);
            chk("pipe_pixel", int'(pipe_pixel), int'(pipe_q[0].v));
            void'(pipe_q.pop_front());
        end else begin
            chk("pipe_idle", int'(pipe_pixel_valid), 0);
        end
        if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
            chk("out_valid", int'(out_valid), 1);
            chk("out_pixel", int'(out_pixel), int'(out_q[0].v));
            chk("out_last", int'(out_last), int'(out_q[0].last));
            void'(out_q.pop_front());
        end else begin
            chk("out_idle_valid", int'(out_valid), 0);
            chk("out_idle_last", int'(out_last), 0);
        end
        if (frame_done) begin
            done_seen++;
            done_cyc = cyc;
        end
    endtask

    task automatic drive_edge();
        edge_in_valid = 1'b1;
        edge_in = 8'($urandom);
        if (edges_fwd < OP) begin
            out_q.push_back('{cyc + 1, edge_in, (edges_fwd + 1) == OP});
            edges_fwd++;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_host_ready", int'(host_ready), 0);
        chk("rst_pipe_pixel", int'(pipe_pixel), 0);
        chk("rst_pipe_valid", int'(pipe_pixel_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_overflow_err", int'(overflow_err), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_col", int'(col), 0);
    endtask

    task automatic run_frame(input scen_t s);
        int xfers = 0;
        int t = 0;
        int k = 0;
        int guard = 0;
        done_seen = 0;
        edges_fwd = 0;
        start = 1'b1;
        tick();
        chk("start_clears_timeout", int'(timeout_err), 0);
        chk("start_clears_overflow", int'(overflow_err), 0);
        chk("busy_run", int'(busy), 1);
        while (xfers < W * H && guard < 200) begin
            guard++;
            chk("host_ready_run", int'(host_ready), 1);
            chk("row_run", int'(row), xfers / W);
            chk("col_run", int'(col), xfers % W);
            if (!s.in_drain && k < s.n_edges) begin
                drive_edge();
                k++;
            end
            if (s.gap == 0 || $urandom_range(0, s.gap) == 0) begin
                host_valid = 1'b1;
                host_pixel = 8'($urandom);
                if (host_ready) begin
                    pipe_q.push_back('{cyc + 1, host_pixel, 1'b0});
                    xfers++;
                    if (xfers == W * H) t = cyc;
                end
            end
            tick();
        end
        chk("run_transfers", xfers, W * H);
        // First FLUSH cycle: handshake closed, position wrapped.
        chk("host_ready_flush", int'(host_ready), 0);
        chk("row_wrap", int'(row), 0);
        chk("col_wrap", int'(col), 0);
        chk("busy_flush", int'(busy), 1);
        for (int i = 0; i < FP; i++) pipe_q.push_back('{t + 2 + i, 8'h00, 1'b0});
        repeat (FP) tick();
        k = 0;
        guard = 0;
        while (done_seen == 0 && guard < 40) begin
            if (s.in_drain && k < s.n_edges) begin
                drive_edge();
                k++;
            end
            tick();
            guard++;
        end
        chk("done_seen", done_seen, 1);
        chk("done_latency", done_cyc - t, s.exp_lat);
        chk("timeout_err", int'(timeout_err), int'(s.exp_to));
        chk("overflow_err", int'(overflow_err), int'(s.exp_ov));
        tick();
        chk("busy_after_done", int'(busy), 0);
        chk("done_single_pulse", done_seen, 1);
        tick();
        chk("timeout_sticky_idle", int'(timeout_err), int'(s.exp_to));
        chk("overflow_sticky_idle", int'(overflow_err), int'(s.exp_ov));
        chk("pipe_q_drained", pipe_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        $display("frame gap=%0d edges=%0d drain=%0d latency=%0d to=%0d ov=%0d",
                 s.gap, s.n_edges, s.in_drain, done_cyc - t, timeout_err, overflow_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // gap, edges, in_drain, timeout, overflow, latency
        tbl[0] = '{0, 2, 1'b0, 1'b0, 1'b0, 5};   // basic frame, outputs during RUN
        tbl[1] = '{1, 0, 1'b1, 1'b1, 1'b0, 9};   // gappy host, drain timeout
        tbl[2] = '{2, 3, 1'b1, 1'b0, 1'b1, 7};   // overflow during DRAIN
        tbl[3] = '{0, 1, 1'b1, 1'b1, 1'b0, 10};  // one output restarts the timeout
        tbl[4] = '{3, 3, 1'b0, 1'b0, 1'b1, 5};   // overflow during RUN
        tbl[5] = '{1, 2, 1'b1, 1'b0, 1'b0, 7};   // both outputs during DRAIN

        rstN = 1'b0; start = 1'b0; abort = 1'b0;
        host_pixel = '0; host_valid = 1'b0; edge_in = '0; edge_in_valid = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        rstN = 1'b1;
        tick();
        check_reset_outputs();

        // Edge results in IDLE are ignored.
        for (int i = 0; i < 3; i++) begin
            edge_in_valid = 1'b1;
            edge_in = 8'hA5;
            tick();
        end
        chk("idle_no_overflow", int'(overflow_err), 0);
        chk("idle_not_busy", int'(busy), 0);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 6; i++) run_frame(tbl[i]);
        end

        // Abort after three transfers.
        done_seen = 0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_pixel = 8'(i + 1);
            pipe_q.push_back('{cyc + 1, 8'(i + 1), 1'b0});
            tick();
        end
        abort = 1'b1;
        tick();
        chk("abort_host_ready", int'(host_ready), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_col_hold", int'(col), 3);
        chk("abort_row_hold", int'(row), 0);
        repeat (3) tick();
        chk("abort_no_done", done_seen, 0);
        $display("abort after 3 transfers: busy=%0d col=%0d", busy, col);
        run_frame(tbl[0]);

        // Start while busy is ignored; reset lands in FLUSH.
        start = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            host_valid = 1'b1;
            host_pixel = 8'(8'h10 + i);
            pipe_q.push_back('{cyc + 1, host_pixel, 1'b0});
            tick();
        end
        start = 1'b1;
        tick();
        chk("start_busy_col", int'(col), 2);
        chk("start_busy_row", int'(row), 0);
        chk("start_busy_busy", int'(busy), 1);
        for (int i = 2; i < W * H; i++) begin
            host_valid = 1'b1;
            host_pixel = 8'(8'h10 + i);
            pipe_q.push_back('{cyc + 1, host_pixel, 1'b0});
            tick();
        end
        pipe_q.push_back('{cyc + 1, 8'h00, 1'b0});
        tick();
        chk("flush_busy_before_reset", int'(busy), 1);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        check_reset_outputs();
        $display("reset during FLUSH: busy=%0d pipe_valid=%0d", busy, pipe_pixel_valid);
        run_frame(tbl[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/canny_frame_controller.md
Name: canny_frame_controller

Overview:
- Frame-level sequencer in front of and behind the Canny edge pipeline.
- Accepts a host pixel stream under a valid/ready handshake and feeds exactly one frame into the pipeline's valid-only pixel input.
- Injects zero flush pixels so the pipeline's line buffers drain, counts edge outputs, and forwards them with a last flag.
- Signals frame completion, drain timeout and output overflow.

Parameters:
- IMG_WIDTH, 64, pixels per row.
- IMG_HEIGHT, 64, rows per frame.
- FLUSH_PIXELS, 640, zero pixels injected after the frame; must be at least the total pipeline fill latency in pixels.
- OUT_PIXELS, 3136, edge pixels expected per frame.
- DRAIN_TIMEOUT, 1024, idle cycles allowed in DRAIN before error.

Ports:
- clk  in  1  clock.
- rstN  in  1  synchronous active-low reset.
- start  in  1  single-cycle frame start request.
- abort  in  1  single-cycle abort request.
- host_pixel  in  8  host pixel data.
- host_valid  in  1  host pixel valid.
- host_ready  out  1  controller accepts host pixel.
- pipe_pixel  out  8  pixel to pipeline pixel_in.
- pipe_pixel_valid  out  1  to pipeline pixel_in_valid.
- edge_in  in  8  pipeline pixel_out.
- edge_in_valid  in  1  pipeline pixel_out_valid.
- out_pixel  out  8  forwarded edge pixel.
- out_valid  out  1  forwarded edge valid.
- out_last  out  1  high with the OUT_PIXELS-th forwarded pixel.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky drain timeout.
- overflow_err  out  1  sticky excess-output flag.
- row  out  $clog2(IMG_HEIGHT)  row of the next host pixel.
- col  out  $clog2(IMG_WIDTH)  column of the next host pixel.

Behaviour:
- Reset (rstN=0 at a clk edge): state IDLE; all outputs and counters 0; sticky errors cleared.
- States: IDLE, RUN, FLUSH, DRAIN, DONE.
- IDLE:
  - host_ready=0.
  - start → RUN; clears row, col, in_count, flush_cnt, out_count, timeout_cnt, timeout_err, overflow_err.
- RUN:
  - host_ready=1 combinationally.
  - Transfer when host_valid && host_ready. The pipeline has no backpressure, so every transfer drives pipe_pixel=host_pixel and pipe_pixel_valid=1 on the next cycle (registered, latency 1). Otherwise pipe_pixel_valid=0.
  - col increments per transfer; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - The transfer at row=IMG_HEIGHT-1, col=IMG_WIDTH-1 → FLUSH; row/col wrap to 0.
- FLUSH:
  - host_ready=0.
  - Drives pipe_pixel=0, pipe_pixel_valid=1 every cycle for FLUSH_PIXELS cycles, then → DRAIN.
  - FLUSH_PIXELS=0 skips directly to DRAIN.
- DRAIN:
  - pipe_pixel_valid=0.
  - timeout_cnt increments each cycle with no edge_in_valid and resets to 0 on edge_in_valid.
  - out_count==OUT_PIXELS → DONE.
  - timeout_cnt reaching DRAIN_TIMEOUT → sets timeout_err, → DONE.
- DONE: frame_done=1 for exactly one cycle, then → IDLE.
- Output path (all states except IDLE):
  - edge_in_valid with out_count<OUT_PIXELS: out_pixel=edge_in and out_valid=1 next cycle; out_count increments.
  - out_last=1 when the forwarded pixel makes out_count==OUT_PIXELS.
  - edge_in_valid with out_count==OUT_PIXELS: pixel is dropped (out_valid=0) and overflow_err is set.
  - Outputs arriving during RUN/FLUSH are counted normally.
  - In IDLE, edge_in_valid is ignored and does not set overflow_err.
- Simultaneous events:
  - start while busy is ignored.
  - abort has priority over every transition: → IDLE next cycle, host_ready=0, pipe_pixel_valid=0, no frame_done; counters hold until the next start; sticky errors hold.
  - abort and start together in IDLE: start wins.
  - Final RUN transfer coinciding with edge_in_valid: both are processed in the same cycle.
- Widths:
  - in_count, out_count, flush_cnt, timeout_cnt are each $clog2 of their limit plus 1 bit.
  - No counter wraps except row/col.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=2, FLUSH_PIXELS=3, OUT_PIXELS=2, DRAIN_TIMEOUT=5):
- Basic frame: start, host_valid held with data 1..8 → pipe_pixel 1..8 each one cycle after its transfer, then 3 cycles of valid zeros. edge_in_valid pulses twice with 0xFF → out_valid twice, out_last on the 2nd, frame_done 1 cycle later, busy then low.
- Gappy host: host_valid toggles every other cycle → exactly 8 pipe_pixel_valid pulses. row/col read (0,0)…(1,3), wrapping to (0,0) on entering FLUSH.
- Timeout: no edge_in_valid after flush → timeout_err=1 after 5 DRAIN cycles, then frame_done. timeout_err stays high in IDLE; the next start clears it.
- Overflow: 3 edge_in_valid pulses during DRAIN → 2 forwarded, 3rd dropped, overflow_err=1.
- Abort mid-RUN: after 3 transfers assert abort → host_ready=0 next cycle, state IDLE, no frame_done. A new start then restarts row=0, col=0.
- Reset mid-FLUSH: rstN low for one edge → all outputs 0, IDLE; start while busy during RUN has no effect on counters.
